// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_seq_pkg;

  // Controller phases: parked, blanking after a change, sampling.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  // Channel encoding used by the mux (0=a, 1=b, 2=c, 3=d).
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  // Run-mode encoding of the mode input.
  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_MAN  = 1'b1;

  // Phase counter width; DWELL and SETTLE are limited to 1..255.
  localparam int CNT_W = 8;

  // Auto-scan successor: a->b->c->d->a.
  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return c + 2'd1;
  endfunction

  // Terminal count of an n-cycle phase, sized to the counter.
  function automatic logic [CNT_W-1:0] last_cnt(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/mux_sel_decode.sv
// Channel number to 4:1 mux select-line decode. Purely combinational;
// driven from a registered channel so selects only move at clock edges.
module mux_sel_decode
  import mux_seq_pkg::*;
(
  input  logic [1:0] i_ch,
  output logic       o_s00,
  output logic       o_s01,
  output logic       o_s1
);

  // s00 picks b within the a/b pair, s01 picks d within c/d, s1 picks the pair.
  always_comb begin
    o_s00 = (i_ch == CH_B);
    o_s01 = (i_ch == CH_D);
    o_s1  = i_ch[1];
  end

endmodule

// File: rtl/mux_41_scan_ctrl.sv
// Scan controller for a 4:1 mux: auto-rotates or holds a channel, takes
// manual channel requests through valid/ready, and blanks sample_valid for
// SETTLE cycles after every channel change or enable.
module mux_41_scan_ctrl
  import mux_seq_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode,
  input  logic       req_valid,
  input  logic [1:0] req_ch,
  output logic       req_ready,
  output logic       s00,
  output logic       s01,
  output logic       s1,
  output logic [1:0] ch,
  output logic       sample_valid,
  output logic       wrap
);

  localparam logic [CNT_W-1:0] DWELL_LAST  = last_cnt(DWELL);
  localparam logic [CNT_W-1:0] SETTLE_LAST = last_cnt(SETTLE);

  state_t           r_state;
  logic [1:0]       r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sample_valid;
  logic             r_wrap;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_ch_change;

  // Ready depends only on registered state plus the en/mode levels.
  always_comb begin
    w_req_ready = en && (mode == MODE_MAN) && (r_state == ST_DWELL);
    w_accept    = w_req_ready && req_valid;
    w_ch_change = w_accept && (req_ch != r_ch);
  end

  // Controller FSM; channel, counter, sample_valid and wrap are all registered
  // here so no output depends combinationally on request inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ch           <= CH_A;
      r_cnt          <= '0;
      r_sample_valid <= 1'b0;
      r_wrap         <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!en) begin
        // Park: channel held, sampling blocked until re-enabled and settled.
        r_state        <= ST_IDLE;
        r_cnt          <= '0;
        r_sample_valid <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state        <= ST_SETTLE;
            r_cnt          <= '0;
            r_sample_valid <= 1'b0;
          end
          ST_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_state        <= ST_DWELL;
              r_cnt          <= '0;
              r_sample_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          ST_DWELL: begin
            if (mode == MODE_MAN) begin
              // Counter frozen at 0 so a later switch to auto dwells in full.
              r_cnt <= '0;
              if (w_ch_change) begin
                r_ch           <= req_ch;
                r_state        <= ST_SETTLE;
                r_sample_valid <= 1'b0;
              end
            end else if (r_cnt == DWELL_LAST) begin
              r_ch           <= next_ch(r_ch);
              r_state        <= ST_SETTLE;
              r_cnt          <= '0;
              r_sample_valid <= 1'b0;
              r_wrap         <= (r_ch == CH_D);
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_sample_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  mux_sel_decode u_dec (
    .i_ch  (r_ch),
    .o_s00 (s00),
    .o_s01 (s01),
    .o_s1  (s1)
  );

  // Output drive from registered state.
  always_comb begin
    ch           = r_ch;
    sample_valid = r_sample_valid;
    wrap         = r_wrap;
    req_ready    = w_req_ready;
  end

endmodule

// File: tb/tb_mux_41_scan_ctrl.sv
// Bench for mux_41_scan_ctrl: two instances (default timing and DWELL=SETTLE=1)
// share one stimulus stream and are compared every cycle to a countdown model.
module tb_mux_41_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, en, mode, req_valid;
  logic [1:0] req_ch;

  logic       rdy_o[2];
  logic       s00_o[2];
  logic       s01_o[2];
  logic       s1_o[2];
  logic [1:0] ch_o[2];
  logic       sv_o[2];
  logic       wrap_o[2];

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_41_scan_ctrl #(.DWELL(4), .SETTLE(2)) u0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .req_valid(req_valid),
    .req_ch(req_ch), .req_ready(rdy_o[0]), .s00(s00_o[0]), .s01(s01_o[0]),
    .s1(s1_o[0]), .ch(ch_o[0]), .sample_valid(sv_o[0]), .wrap(wrap_o[0])
  );

  mux_41_scan_ctrl #(.DWELL(1), .SETTLE(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .req_valid(req_valid),
    .req_ch(req_ch), .req_ready(rdy_o[1]), .s00(s00_o[1]), .s01(s01_o[1]),
    .s1(s1_o[1]), .ch(ch_o[1]), .sample_valid(sv_o[1]), .wrap(wrap_o[1])
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // Model: enabled flag, remaining blank cycles, valid cycles spent on channel.
  int m_ch[2];
  int m_blank[2];
  int m_dw[2];
  bit m_on[2];
  bit m_wrap[2];
  bit m_init = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int sp, dp;
      sp = (i == 0) ? 2 : 1;
      dp = (i == 0) ? 4 : 1;
      if (reset) begin
        m_on[i] = 1'b0; m_ch[i] = 0; m_blank[i] = 0; m_dw[i] = 0; m_wrap[i] = 1'b0;
      end else begin
        m_wrap[i] = 1'b0;
        if (!en) m_on[i] = 1'b0;
        else if (!m_on[i]) begin
          m_on[i] = 1'b1; m_blank[i] = sp; m_dw[i] = 0;
        end else if (m_blank[i] > 0) begin
          m_blank[i]--; m_dw[i] = 0;
        end else if (mode) begin
          m_dw[i] = 0;
          if (req_valid && int'(req_ch) != m_ch[i]) begin
            m_ch[i] = int'(req_ch); m_blank[i] = sp;
          end
        end else begin
          m_dw[i]++;
          if (m_dw[i] == dp) begin
            m_wrap[i]  = (m_ch[i] == 3);
            m_ch[i]    = (m_ch[i] + 1) % 4;
            m_blank[i] = sp;
            m_dw[i]    = 0;
          end
        end
      end
    end
    if (reset) m_init = 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        bit sv;
        sv = m_on[i] && (m_blank[i] == 0);
        chk($sformatf("u%0d_ch", i),   int'(ch_o[i]),   m_ch[i]);
        chk($sformatf("u%0d_s00", i),  int'(s00_o[i]),  int'(m_ch[i] == 1));
        chk($sformatf("u%0d_s01", i),  int'(s01_o[i]),  int'(m_ch[i] == 3));
        chk($sformatf("u%0d_s1", i),   int'(s1_o[i]),   int'(m_ch[i] >= 2));
        chk($sformatf("u%0d_sv", i),   int'(sv_o[i]),   int'(sv));
        chk($sformatf("u%0d_wrap", i), int'(wrap_o[i]), int'(m_wrap[i]));
        chk($sformatf("u%0d_rdy", i),  int'(rdy_o[i]),  int'(en && mode && sv));
      end
    end
  end

  function automatic int sel0();
    return int'({s1_o[0], s01_o[0], s00_o[0]});
  endfunction

  initial begin
    bit got_sv;
    reset = 1'b1; en = 1'b0; mode = 1'b0; req_valid = 1'b0; req_ch = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ch", int'(ch_o[0]), 0);
    chk("rst_sel", sel0(), 0);
    chk("rst_sv", int'(sv_o[0]), 0);
    chk("rst_wrap", int'(wrap_o[0]), 0);
    chk("rst_rdy", int'(rdy_o[0]), 0);
    reset = 1'b0; en = 1'b1; mode = 1'b0;

    // Auto scan from reset: hand-computed points of the 6-cycle/channel pattern.
    for (int n = 1; n <= 26; n++) begin
      @(posedge clk); #2;
      case (n)
        1:  begin chk("a1_sv", int'(sv_o[0]), 0); chk("b1_sv", int'(sv_o[1]), 0); end
        2:  begin chk("a2_sv", int'(sv_o[0]), 0); chk("b2_sv", int'(sv_o[1]), 1); end
        3:  begin chk("a3_sv", int'(sv_o[0]), 1); chk("b3_sv", int'(sv_o[1]), 0);
                  chk("b3_ch", int'(ch_o[1]), 1); end
        6:  begin chk("a6_sv", int'(sv_o[0]), 1); chk("a6_ch", int'(ch_o[0]), 0); end
        7:  begin chk("a7_sv", int'(sv_o[0]), 0); chk("a7_ch", int'(ch_o[0]), 1);
                  chk("a7_sel", sel0(), 1); end
        9:  begin chk("b9_ch", int'(ch_o[1]), 0); chk("b9_wrap", int'(wrap_o[1]), 1); end
        13: begin chk("a13_ch", int'(ch_o[0]), 2); chk("a13_sel", sel0(), 4); end
        19: begin chk("a19_ch", int'(ch_o[0]), 3); chk("a19_sel", sel0(), 6);
                  chk("a19_sv", int'(sv_o[0]), 0); end
        21: chk("a21_sv", int'(sv_o[0]), 1);
        24: begin chk("a24_ch", int'(ch_o[0]), 3); chk("a24_wrap", int'(wrap_o[0]), 0); end
        25: begin chk("a25_ch", int'(ch_o[0]), 0); chk("a25_wrap", int'(wrap_o[0]), 1);
                  chk("a25_sv", int'(sv_o[0]), 0); end
        26: chk("a26_wrap", int'(wrap_o[0]), 0);
        default: ;
      endcase
    end

    // Manual: wait (bounded) for the default instance to reach sampling.
    mode = 1'b1;
    got_sv = 1'b0;
    for (int k = 0; k < 20 && !got_sv; k++) begin
      @(posedge clk); #2;
      got_sv = sv_o[0];
    end
    chk("man_dwell_reached", int'(got_sv), 1);
    req_valid = 1'b1; req_ch = 2'd2;
    #1 chk("m_rdy", int'(rdy_o[0]), 1);
    @(posedge clk); #2;
    chk("m_ch2", int'(ch_o[0]), 2);
    chk("m_sel2", sel0(), 4);
    chk("m_sv0", int'(sv_o[0]), 0);
    chk("m_rdy_settle", int'(rdy_o[0]), 0);
    @(posedge clk); #2;
    chk("m_sv0b", int'(sv_o[0]), 0);
    @(posedge clk); #2;
    chk("m_sv1", int'(sv_o[0]), 1);
    chk("m_rdy_same", int'(rdy_o[0]), 1);
    @(posedge clk); #2;
    chk("m_same_ch", int'(ch_o[0]), 2);
    chk("m_same_sv", int'(sv_o[0]), 1);
    req_ch = 2'd3;
    @(posedge clk); #2;
    chk("m_ch3", int'(ch_o[0]), 3);
    req_ch = 2'd1;
    #1 chk("m_rdy_blk", int'(rdy_o[0]), 0);
    @(posedge clk); #2;
    chk("m_hold3", int'(ch_o[0]), 3);
    // Reset mid-settle with a live request: reset must win.
    reset = 1'b1;
    @(posedge clk); #2;
    chk("r_ch", int'(ch_o[0]), 0);
    chk("r_sel", sel0(), 0);
    chk("r_sv", int'(sv_o[0]), 0);
    chk("r_rdy", int'(rdy_o[0]), 0);
    reset = 1'b0; req_valid = 1'b0; mode = 1'b0;

    // Enable drop in auto mode, then re-enable (model-checked).
    repeat (9) @(posedge clk);
    #1 en = 1'b0;
    repeat (5) @(posedge clk);
    #1 en = 1'b1;
    repeat (15) @(posedge clk);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 149) == 0);
      en        = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      req_valid = $urandom_range(0, 1) == 1;
      req_ch    = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
